acc_load_counter: RTL and testbench

- Address counter used by the accumulator load path of the TPU.
- On a load it captures a start address (base), then produces base + offset, where the offset steps through 0..MATRIX_WIDTH-1 and wraps. This sweeps one matrix-width block of accumulator rows repeatedly.
- Before the first load it counts freely from 0.
- Sits between the control unit (start address, load strobe) and the accumulator read/write address inputs.

---
 rtl/acc_load_counter.sv | 56 +++++
 tb/tb_acc_load_counter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/acc_load_counter.sv
// Accumulator load-path address counter: base + offset, where the offset
// runs freely until the first load and then wraps every MATRIX_WIDTH steps.
module acc_load_counter #(
    parameter int COUNTER_WIDTH = 8,
    parameter int MATRIX_WIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] start_val,
    input  logic                     load,
    output logic [COUNTER_WIDTH-1:0] ctr_val
);

    localparam logic [COUNTER_WIDTH-1:0] LP_LAST =
        COUNTER_WIDTH'(MATRIX_WIDTH - 1);

    logic [COUNTER_WIDTH-1:0] r_base;
    logic [COUNTER_WIDTH-1:0] r_offset;
    logic                     r_wrap;
    logic [COUNTER_WIDTH-1:0] r_ctr;

    logic [COUNTER_WIDTH-1:0] w_offset_nxt;
    logic [COUNTER_WIDTH-1:0] w_sum_nxt;

    always_comb begin
        w_offset_nxt = r_offset + COUNTER_WIDTH'(1);
        if (r_wrap && (r_offset == LP_LAST)) begin
            w_offset_nxt = '0;
        end
        w_sum_nxt = r_base + w_offset_nxt;
    end

    // Load wins over counting; disabled cycles drop the load entirely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base   <= '0;
            r_offset <= '0;
            r_wrap   <= 1'b0;
            r_ctr    <= '0;
        end else if (enable) begin
            if (load) begin
                r_base   <= start_val;
                r_offset <= '0;
                r_wrap   <= 1'b1;
                r_ctr    <= start_val;
            end else begin
                r_offset <= w_offset_nxt;
                r_ctr    <= w_sum_nxt;
            end
        end
    end

    assign ctr_val = r_ctr;

endmodule

// File: tb/tb_acc_load_counter.sv
// Directed bench for acc_load_counter: free count, load/sweep, freeze,
// reload with overflow, and asynchronous reset mid-sweep.
module tb_acc_load_counter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] start_val;
    logic       load;
    logic [7:0] ctr_val;

    int checks;
    int errors;

    acc_load_counter #(
        .COUNTER_WIDTH(8),
        .MATRIX_WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .start_val(start_val),
        .load     (load),
        .ctr_val  (ctr_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        start_val = 8'd0;
        tick();
        tick();
        chk("reset", ctr_val, 8'd0);
        rst = 1'b1;

        // Loads while disabled are ignored
        load      = 1'b1;
        start_val = 8'd0;
        tick();
        chk("idle_ld0", ctr_val, 8'd0);
        start_val = 8'd5;
        tick();
        chk("idle_ld5", ctr_val, 8'd0);
        load = 1'b0;
        tick();
        chk("idle_after", ctr_val, 8'd0);

        // Free count, no MATRIX_WIDTH wrap, 255 -> 0
        enable = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            tick();
            chk("free", ctr_val, 8'(k));
        end

        // Load 11 and sweep 11..14
        load      = 1'b1;
        start_val = 8'd11;
        tick();
        chk("load11", ctr_val, 8'd11);
        load = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            chk("sweep", ctr_val, 8'(11 + (i % 4)));
        end

        // Freeze at 13, then resume
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("freeze", ctr_val, 8'd13);
        end
        enable = 1'b1;
        tick();
        chk("resume14", ctr_val, 8'd14);
        tick();
        chk("resume11", ctr_val, 8'd11);
        tick();
        chk("resume12", ctr_val, 8'd12);

        // Reload near the top: mod-256 truncation
        load      = 1'b1;
        start_val = 8'd254;
        tick();
        chk("load254", ctr_val, 8'd254);
        load = 1'b0;
        tick();
        chk("ovf255", ctr_val, 8'd255);
        tick();
        chk("ovf0", ctr_val, 8'd0);
        tick();
        chk("ovf1", ctr_val, 8'd1);
        tick();
        chk("ovf_wrap", ctr_val, 8'd254);
        tick();
        tick();
        tick();
        chk("pre_wrap", ctr_val, 8'd1);
        // offset is at MATRIX_WIDTH-1: load must beat the wrap
        load      = 1'b1;
        start_val = 8'd100;
        tick();
        chk("ld_on_wrap", ctr_val, 8'd100);
        load = 1'b0;
        tick();
        chk("after_ld", ctr_val, 8'd101);

        // Async reset between edges
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_rst", ctr_val, 8'd0);
        tick();
        chk("rst_hold", ctr_val, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("post_rst", ctr_val, 8'(k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
